// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the data-memory bridge: FSM state encoding and
// access-size codes used on the SRAM-like data bus.
package cpu_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Size code 3 has no bus meaning; the bus only ever sees byte/half/word.
  function automatic logic [1:0] bus_size(input logic [1:0] size);
    case (size)
      SZ_BYTE: return SZ_BYTE;
      SZ_HALF: return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bridge.sv
// Bridges the M-stage load/store onto a split-transaction (addr_ok/data_ok)
// data bus, stalling the pipeline until the single outstanding access completes.
module dmem_bridge
  import cpu_defs::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic              mem_wr,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_err,
  input  logic              pipe_stall,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_stall,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  state_t            state, state_next;
  logic [DATA_W-1:0] rdata_hold;
  logic              capture;
  logic              go;

  assign go = mem_en & ~mem_addr_err;

  // The M stage is frozen for the whole transaction, so the bus command
  // fields can follow the pipeline inputs directly without registering.
  assign data_wr    = mem_wr;
  assign data_size  = bus_size(mem_size);
  assign data_addr  = mem_addr;
  assign data_wdata = mem_wdata;

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    data_req   = 1'b0;
    mem_stall  = 1'b0;
    mem_rdata  = rdata_hold;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          data_req   = 1'b1;
          mem_stall  = 1'b1;
          state_next = data_addr_ok ? WAIT : REQ;
        end
      end
      REQ: begin
        // Held until accepted even if mem_en drops: a request on the bus
        // cannot be withdrawn.
        data_req  = 1'b1;
        mem_stall = 1'b1;
        if (data_addr_ok) state_next = WAIT;
      end
      WAIT: begin
        if (data_data_ok) begin
          mem_rdata  = data_rdata;
          capture    = ~mem_wr;
          state_next = pipe_stall ? DONE : IDLE;
        end else begin
          mem_stall = 1'b1;
        end
      end
      DONE: begin
        // Result already delivered; wait for the pipeline to move on
        // without reissuing the same access.
        if (!pipe_stall) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rdata_hold <= '0;
    end else begin
      state <= state_next;
      if (capture) rdata_hold <= data_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: a bus-slave task drives stimulus and pushes
// expected load data; a negedge monitor checks mem_rdata on each completion.
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_en = 1'b0;
  logic        mem_wr = 1'b0;
  logic [1:0]  mem_size = 2'd0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_addr_err = 1'b0;
  logic        pipe_stall = 1'b0;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok = 1'b0;
  logic        data_data_ok = 1'b0;
  logic [31:0] data_rdata = '0;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  dmem_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_err(mem_addr_err),
    .pipe_stall(pipe_stall), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a load completes when the bus returns data_ok and the stall drops.
  always @(negedge clk) begin
    if (rst && mem_en && !mem_wr && data_data_ok && !mem_stall) begin
      if (exp_q.size() == 0) check("unexpected_completion", 32'd1, 32'd0);
      else check("load_rdata", mem_rdata, exp_q.pop_front());
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One M-stage access with a bus slave that accepts after alat request
  // cycles and responds dlat cycles after acceptance.
  task automatic access(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int alat, input int dlat, input int pst_extra,
                        input int exp_stall, input int exp_req);
    int  nreq = 0, nstall = 0, nhs = 0, wcnt = 0;
    bit  accepted = 0, done = 0;
    logic [1:0] exp_size;
    exp_size     = (size == 2'd3) ? 2'd2 : size;
    mem_en       = 1'b1;
    mem_wr       = wr;
    mem_size     = size;
    mem_addr     = addr;
    mem_wdata    = wdata;
    mem_addr_err = 1'b0;
    pipe_stall   = (pst_extra > 0);
    if (!wr) exp_q.push_back(rdata);
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      data_addr_ok = !accepted && (nreq >= alat);
      data_data_ok = accepted && (wcnt >= dlat);
      data_rdata   = data_data_ok ? rdata : 32'hBAD0_BAD0;
      @(negedge clk);
      if (cyc == 0) check("first_cycle_req", {31'd0, data_req}, 32'd1);
      if (data_req) begin
        nreq++;
        check("bus_wr", {31'd0, data_wr}, {31'd0, wr});
        check("bus_size", {30'd0, data_size}, {30'd0, exp_size});
        check("bus_addr", data_addr, addr);
        check("bus_wdata", data_wdata, wdata);
      end
      if (mem_stall) nstall++;
      if (data_data_ok) begin
        done = 1;
        check("stall_at_done", {31'd0, mem_stall}, 32'd0);
      end
      if (accepted) wcnt++;
      if (data_req && data_addr_ok) begin
        nhs++;
        accepted = 1;
      end
      next_cycle();
    end
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    if (!done) check("access_timeout", 32'd0, 32'd1);
    check("stall_cycles", nstall, exp_stall);
    check("req_cycles", nreq, exp_req);
    check("handshakes", nhs, 32'd1);
    for (int i = 0; i <= pst_extra && pst_extra > 0; i++) begin
      if (i == pst_extra) pipe_stall = 1'b0;
      @(negedge clk);
      check("hold_no_req", {31'd0, data_req}, 32'd0);
      check("hold_no_stall", {31'd0, mem_stall}, 32'd0);
      check("hold_rdata", mem_rdata, rdata);
      next_cycle();
    end
    pipe_stall = 1'b0;
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("reset_rdata", mem_rdata, 32'd0);
    check("reset_stall", {31'd0, mem_stall}, 32'd0);
    check("reset_req", {31'd0, data_req}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    next_cycle();

    // Zero-wait load: accepted immediately, data one cycle into WAIT.
    access(1'b0, 2'd2, 32'h8000_1000, 32'h0, 32'hDEAD_BEEF, 0, 1, 0, 2, 1);

    // Store with acceptance delayed three cycles; hold must keep the load value.
    access(1'b1, 2'd1, 32'h8000_2002, 32'hBEEF_0000, 32'h0, 3, 0, 0, 4, 4);
    mem_en = 1'b0;
    @(negedge clk);
    check("store_keeps_hold", mem_rdata, 32'hDEAD_BEEF);
    next_cycle();

    // Load completing under an external stall lasting two extra cycles.
    access(1'b0, 2'd2, 32'h8000_3000, 32'h0, 32'h1234_5678, 0, 0, 2, 1, 1);

    // Address error suppresses the access even with addr_ok offered.
    mem_en = 1'b1;
    mem_addr_err = 1'b1;
    data_addr_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("adel_no_req", {31'd0, data_req}, 32'd0);
      check("adel_no_stall", {31'd0, mem_stall}, 32'd0);
      next_cycle();
    end
    data_addr_ok = 1'b0;
    mem_addr_err = 1'b0;
    mem_en = 1'b0;
    next_cycle();

    // Back-to-back loads; the second uses size code 3 (mapped to word).
    access(1'b0, 2'd2, 32'h8000_4000, 32'h0, 32'h0000_0011, 0, 1, 0, 2, 1);
    access(1'b0, 2'd3, 32'h8000_4004, 32'h0, 32'h0000_0022, 1, 1, 0, 3, 2);

    // Reset asserted while waiting for data_ok.
    mem_en = 1'b1;
    mem_wr = 1'b0;
    mem_size = 2'd2;
    mem_addr = 32'h8000_5000;
    data_addr_ok = 1'b1;
    @(negedge clk);
    check("rst_pre_req", {31'd0, data_req}, 32'd1);
    next_cycle();
    data_addr_ok = 1'b0;
    @(negedge clk);
    check("rst_wait_stall", {31'd0, mem_stall}, 32'd1);
    @(posedge clk);
    #2;
    mem_en = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_async_stall", {31'd0, mem_stall}, 32'd0);
    check("rst_async_req", {31'd0, data_req}, 32'd0);
    check("rst_async_rdata", mem_rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    next_cycle();
    data_data_ok = 1'b1;
    data_rdata = 32'h5555_5555;
    @(negedge clk);
    check("spurious_rdata", mem_rdata, 32'd0);
    check("spurious_stall", {31'd0, mem_stall}, 32'd0);
    next_cycle();
    data_data_ok = 1'b0;
    @(negedge clk);
    check("spurious_after", mem_rdata, 32'd0);
    next_cycle();

    // Recovery: byte load after reset.
    access(1'b0, 2'd0, 32'h8000_6003, 32'h0, 32'h0000_00AB, 0, 2, 0, 3, 1);
    mem_en = 1'b0;
    next_cycle();
    next_cycle();
    check("queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Converts the memory-stage data access (address, write data, size, write flag) into an SRAM-like split-transaction bus: request/addr_ok, then data_ok/rdata.
- Sits directly downstream of the datapath's memory-visit stage, between it and the data cache/AXI adapter.
- Raises a stall request to the hazard unit until the access completes.
- Holds the read result while the rest of the pipeline is still stalled, so one pipeline access never issues twice.

Parameters:
- ADDR_W, 32, width of the data bus address.
- DATA_W, 32, width of the data bus data; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_en  in  1  M stage performs a load or store this cycle.
- mem_wr  in  1  1 = store, 0 = load.
- mem_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- mem_addr  in  ADDR_W  byte address (aluoutM).
- mem_wdata  in  DATA_W  lane-aligned store data (writedata2M).
- mem_addr_err  in  1  address error from the memory selector; suppresses the access.
- pipe_stall  in  1  stall from any other source holding the M stage.
- mem_rdata  out  DATA_W  load data to the M stage.
- mem_stall  out  1  stall request to the hazard unit.
- data_req  out  1  bus request.
- data_wr  out  1  bus write flag.
- data_size  out  2  bus size.
- data_addr  out  ADDR_W  bus address.
- data_wdata  out  DATA_W  bus write data.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  response valid; also write completion.
- data_rdata  in  DATA_W  read response.

Behaviour:
- States: IDLE, REQ, WAIT, DONE, encoded in 2 bits.
- Only one outstanding transaction is allowed.
- Valid access: `go = mem_en & ~mem_addr_err`.
- Reset (rst=0, asynchronous): state=IDLE, rdata_hold=0, mem_rdata=0, mem_stall=0, data_req=0.
- data_wr, data_size, data_addr and data_wdata are driven combinationally from the mem_* inputs. They stay stable because the M stage is stalled for the whole transaction.
- data_size: mem_size, with 3 mapped to 2.
- data_req = (IDLE & go) | REQ. It is deasserted in WAIT and DONE.
- IDLE transitions:
  - go & data_addr_ok: go to WAIT, since the handshake completes in the same cycle.
  - go & ~data_addr_ok: go to REQ.
  - ~go: stay in IDLE.
- REQ transitions:
  - data_addr_ok: go to WAIT.
  - otherwise: stay; data_req stays high.
- WAIT transitions, on data_data_ok:
  - load: capture data_rdata into rdata_hold.
  - pipe_stall=1: go to DONE.
  - pipe_stall=0: go to IDLE.
- DONE: go to IDLE on ~pipe_stall; no new request is issued while in DONE.
- mem_stall = (IDLE & go) | REQ | (WAIT & ~data_data_ok). It is deasserted in the completion cycle and in DONE.
- mem_rdata:
  - WAIT & data_data_ok: data_rdata, zero latency.
  - DONE: rdata_hold.
  - otherwise: rdata_hold, which keeps the last load value.
- Boundary conditions:
  - data_data_ok in IDLE/REQ/DONE is ignored. The bus must not return data_ok in the same cycle as the matching addr_ok.
  - data_addr_ok outside IDLE/REQ is ignored.
  - mem_addr_err=1: no request, no stall, state unchanged.
  - mem_en falling while in REQ is a pipeline protocol error. The request is still held until accepted.
  - Back-to-back accesses: a new access starts only from IDLE. The cycle after completion (without pipe_stall) with go=1 issues the next request immediately.
  - Reset mid-transaction returns to IDLE. The bus slave must be reset together with the bridge; no stale data_ok is tolerated.
  - Stores: data_rdata is not captured, and rdata_hold keeps its previous value.

Decomposition:
- Shared package (cpu_defs): state enum {IDLE, REQ, WAIT, DONE}, size constants SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2.
- No sub-module; a single FSM plus a holding register is sufficient.

Test Plan:
- Load, zero-wait bus: mem_en=1, wr=0, size=2, addr=0x80001000, addr_ok same cycle, data_ok one cycle later with 0xDEADBEEF.
  -> mem_stall high for 2 cycles, mem_rdata=0xDEADBEEF in the completion cycle, state IDLE after it.
- Store with addr_ok delayed 3 cycles:
  -> data_req stays high for 4 cycles with data_wr=1 and size and wdata stable; mem_stall drops on data_ok; exactly one addr_ok handshake occurs.
- Load completes while pipe_stall=1 for 2 extra cycles, data 0x12345678:
  -> state DONE, no second data_req, mem_rdata holds 0x12345678 until pipe_stall falls, then IDLE.
- mem_addr_err=1 with mem_en=1:
  -> data_req=0 and mem_stall=0 throughout.
- rst pulled low while in WAIT:
  -> outputs reset immediately (asynchronously); after release, a spurious data_ok is ignored and mem_rdata=0.
- Two back-to-back loads (0x11, then 0x22):
  -> the second data_req is asserted in the cycle after the first data_ok; mem_rdata shows 0x11, then 0x22.
